// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: request, key-schedule and result handshake bundle for aes_round_ctrl
interface aes_round_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] key_len;
    logic       key_valid;
    logic       ld_state;
    logic       round_en;
    logic       mix_bypass;
    logic [3:0] round_idx;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       err;
    modport master (
        output in_valid, key_len, key_valid, out_ready,
        input  in_ready, ld_state, round_en, mix_bypass, round_idx, out_valid, busy, err
    );
    modport slave (
        input  in_valid, key_len, key_valid, out_ready,
        output in_ready, ld_state, round_en, mix_bypass, round_idx, out_valid, busy, err
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: AES round sequencer (IDLE/ROUND/DONE) driving the round datapath.
// Define AES_CTRL_ABORT_EN to add an abort input that cancels a block in flight.
module aes_round_ctrl #(
    parameter bit SUPPORT_256 = 1'b1
) (
    input logic clk,
    input logic reset,
`ifdef AES_CTRL_ABORT_EN
    input logic abort,
`endif
    aes_round_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
    state_t     state, state_nx;
    logic [3:0] idx, idx_nx, nr, nr_nx;
    logic       key_ok, abort_w;
`ifdef AES_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif
    assign key_ok         = (bus.key_len == 2'b00) || (bus.key_len == 2'b01) || (bus.key_len == 2'b10 && SUPPORT_256);
    assign bus.in_ready   = state == IDLE && !reset;
    assign bus.ld_state   = bus.in_ready && bus.in_valid && key_ok && bus.key_valid;
    assign bus.err        = bus.in_ready && bus.in_valid && !key_ok;
    assign bus.round_en   = state == ROUND && bus.key_valid;
    assign bus.mix_bypass = bus.round_en && idx == nr;
    assign bus.out_valid  = state == DONE;
    assign bus.busy       = state != IDLE;
    assign bus.round_idx  = idx;
    // Abort outranks round progress and the output handshake
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        nr_nx    = nr;
        if (bus.ld_state) begin
            state_nx = ROUND;
            idx_nx   = 4'd1;
            nr_nx    = 4'd10 + {1'b0, bus.key_len, 1'b0};
        end else if (abort_w && state != IDLE) begin
            state_nx = IDLE;
            idx_nx   = 4'd0;
        end else if (bus.mix_bypass) begin
            state_nx = DONE;
        end else if (bus.round_en) begin
            idx_nx = idx + 4'd1;
        end else if (bus.out_valid && bus.out_ready) begin
            state_nx = IDLE;
            idx_nx   = 4'd0;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= 4'd0;
            nr    <= 4'd10;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            nr    <= nr_nx;
        end
    end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed and randomized checks of aes_round_ctrl against a round-count model
module tb_aes_round_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    aes_round_ctrl_if bus();
`ifdef AES_CTRL_ABORT_EN
    logic abort = 1'b0;
`endif
    aes_round_ctrl #(.SUPPORT_256(1'b1)) dut (
        .clk(clk),
        .reset(reset),
`ifdef AES_CTRL_ABORT_EN
        .abort(abort),
`endif
        .bus(bus)
    );
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ir, input logic ld, input logic re, input logic mb,
                           input logic [3:0] idx, input logic ov, input logic bz, input logic er);
        chk({tag, ".in_ready"}, bus.in_ready, ir);
        chk({tag, ".ld_state"}, bus.ld_state, ld);
        chk({tag, ".round_en"}, bus.round_en, re);
        chk({tag, ".mix_bypass"}, bus.mix_bypass, mb);
        chk({tag, ".round_idx"}, bus.round_idx, idx);
        chk({tag, ".out_valid"}, bus.out_valid, ov);
        chk({tag, ".busy"}, bus.busy, bz);
        chk({tag, ".err"}, bus.err, er);
    endtask

    // Model: r counts completed rounds; the block is finished once r reaches the key-size round count
    task automatic run_block(input logic [1:0] kl, input int stall_pct, input int stall_at,
                             input int stall_len, input int rdy_delay);
        int   nr_tab[3] = '{10, 12, 14};
        int   nr, r, sc;
        logic kv;
        nr = nr_tab[kl];
        bus.in_valid = 1'b1;
        bus.key_len = kl;
        bus.key_valid = 1'b1;
        bus.out_ready = 1'b0;
        #1;
        chk_out("accept", 1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        r = 0;
        sc = 0;
        for (int c = 0; c < 300 && r < nr; c++) begin
            if (r + 1 == stall_at && sc < stall_len) begin
                kv = 1'b0;
                sc++;
            end else begin
                kv = ($urandom_range(99) >= stall_pct);
            end
            bus.key_valid = kv;
            bus.in_valid = 1'($urandom_range(1));
            bus.key_len = 2'($urandom_range(3));
            bus.out_ready = 1'($urandom_range(1));
            #1;
            chk_out("round", 0, 0, kv, kv && (r + 1 == nr), 4'(r + 1), 0, 1, 0);
            if (kv) r++;
            tick();
        end
        for (int i = 0; i <= rdy_delay; i++) begin
            bus.out_ready = (i == rdy_delay);
            bus.key_valid = 1'($urandom_range(1));
            bus.in_valid = 1'($urandom_range(1));
            #1;
            chk_out("done", 0, 0, 0, 0, 4'(nr), 1, 1, 0);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.key_valid = 1'b0;
        #1;
        chk_out("idle_after", 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.key_len = 2'b00;
        bus.key_valid = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk_out("release", 1, 0, 0, 0, 0, 0, 0, 0);
        // Valid request without a round key is not taken
        bus.in_valid = 1'b1;
        bus.key_len = 2'b01;
        #1;
        chk_out("no_key", 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk_out("no_key_next", 1, 0, 0, 0, 0, 0, 0, 0);
        // Invalid key length pulses err and stays idle
        bus.key_len = 2'b11;
        bus.key_valid = 1'b1;
        #1;
        chk_out("bad_len", 1, 0, 0, 0, 0, 0, 0, 1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk_out("bad_len_next", 1, 0, 0, 0, 0, 0, 0, 0);
        run_block(2'b00, 0, 0, 0, 0);
        run_block(2'b10, 0, 5, 3, 0);
        run_block(2'b01, 0, 0, 0, 4);
        run_block(2'b00, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++)
            run_block(2'($urandom_range(2)), 30, int'($urandom_range(14)), int'($urandom_range(3)), int'($urandom_range(3)));
        // Reset in the middle of a block
        bus.in_valid = 1'b1;
        bus.key_len = 2'b00;
        bus.key_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("mid_idx", bus.round_idx, 7);
        reset = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        tick();
        chk_out("reset_mid", 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk_out("post_reset", 1, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
`ifdef AES_CTRL_ABORT_EN
        bus.in_valid = 1'b1;
        bus.key_len = 2'b10;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("abort_idx", bus.round_idx, 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk_out("post_abort", 1, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
`endif
        bus.key_valid = 1'b0;
        bus.out_ready = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
